// File: rtl/pe_types.sv
// rtl/pe_types.sv - shared types for the PE accumulator controller.

package pe_types;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    WAIT_PIPE,
    DRAIN,
    DONE
  } pe_accum_ctrl_state_t;

  // Pipe counter holds PIPE_LATENCY-1, and PIPE_LATENCY tops out at 15.
  localparam int PIPE_CNT_WIDTH = 4;

  function automatic logic state_is_busy(input pe_accum_ctrl_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/pe_accum_ctrl_if.sv
// rtl/pe_accum_ctrl_if.sv - feature-beat and result handshakes of the accumulator controller.

interface pe_accum_ctrl_if;

  logic i_feature_valid;
  logic o_feature_ready;
  logic o_pe_feature_valid;
  logic o_pe_flush_accumulator;
  logic o_result_capture;
  logic o_result_valid;
  logic i_result_ready;

  modport master (
    output i_feature_valid,
    output i_result_ready,
    input  o_feature_ready,
    input  o_pe_feature_valid,
    input  o_pe_flush_accumulator,
    input  o_result_capture,
    input  o_result_valid
  );

  modport slave (
    input  i_feature_valid,
    input  i_result_ready,
    output o_feature_ready,
    output o_pe_feature_valid,
    output o_pe_flush_accumulator,
    output o_result_capture,
    output o_result_valid
  );

endinterface

// File: rtl/pe_accum_ctrl_cnt.sv
// rtl/pe_accum_ctrl_cnt.sv - loadable down-counter with zero flag; load wins over decrement.

module pe_accum_ctrl_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pe_accum_ctrl.sv
// rtl/pe_accum_ctrl.sv - sequences accumulate/flush/capture/drain for a PE accumulator array.
// Optional PE_ACCUM_CTRL_PERF_EN adds the o_stall_cycles counter.

module pe_accum_ctrl
  import pe_types::*;
#(
  parameter int LEN_WIDTH    = 16,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_accum_len,
  input  logic [LEN_WIDTH-1:0] i_num_windows,
  pe_accum_ctrl_if.slave       ctrl,
  output logic                 o_busy,
`ifdef PE_ACCUM_CTRL_PERF_EN
  output logic [31:0]          o_stall_cycles,
`endif
  output logic                 o_done
);

  localparam logic [PIPE_CNT_WIDTH-1:0] PIPE_LOAD = PIPE_CNT_WIDTH'(PIPE_LATENCY - 1);

  pe_accum_ctrl_state_t state_q, state_d;

  // Counters hold "remaining minus one" so the zero flag marks the last beat/window/cycle.
  logic [LEN_WIDTH-1:0] len_m1_q, len_m1_d;
  logic                 first_q, first_d;

  logic                 beat_load, beat_dec, beat_zero;
  logic [LEN_WIDTH-1:0] beat_load_val;
  logic                 win_load, win_dec, win_zero;
  logic                 pipe_load, pipe_dec, pipe_zero;

  logic feature_ready, flush, capture, result_valid, done;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      len_m1_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_m1_q <= len_m1_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_m1_d      = len_m1_q;
    first_d       = first_q;
    beat_load     = 1'b0;
    beat_load_val = len_m1_q;
    beat_dec      = 1'b0;
    win_load      = 1'b0;
    win_dec       = 1'b0;
    pipe_load     = 1'b0;
    pipe_dec      = 1'b0;
    feature_ready = 1'b0;
    flush         = 1'b0;
    capture       = 1'b0;
    result_valid  = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          // A zero length runs as a single-beat window.
          len_m1_d = (i_accum_len == '0) ? '0 : i_accum_len - LEN_WIDTH'(1);
          if (i_num_windows == '0) begin
            state_d = DONE;
          end else begin
            state_d       = ACCUM;
            beat_load     = 1'b1;
            beat_load_val = len_m1_d;
            win_load      = 1'b1;
            first_d       = 1'b1;
          end
        end
      end

      ACCUM: begin
        feature_ready = 1'b1;
        if (ctrl.i_feature_valid) begin
          flush   = first_q;
          first_d = 1'b0;
          if (beat_zero) begin
            state_d   = WAIT_PIPE;
            pipe_load = 1'b1;
          end else begin
            beat_dec = 1'b1;
          end
        end
      end

      WAIT_PIPE: begin
        if (pipe_zero) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else begin
          pipe_dec = 1'b1;
        end
      end

      DRAIN: begin
        result_valid = 1'b1;
        if (ctrl.i_result_ready) begin
          if (win_zero) begin
            state_d = DONE;
          end else begin
            state_d   = ACCUM;
            win_dec   = 1'b1;
            beat_load = 1'b1;
            first_d   = 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  pe_accum_ctrl_cnt #(.WIDTH(LEN_WIDTH)) u_beat_cnt (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (beat_load),
    .load_val_i (beat_load_val),
    .dec_i      (beat_dec),
    .zero_o     (beat_zero)
  );

  pe_accum_ctrl_cnt #(.WIDTH(LEN_WIDTH)) u_win_cnt (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (win_load),
    .load_val_i (i_num_windows - LEN_WIDTH'(1)),
    .dec_i      (win_dec),
    .zero_o     (win_zero)
  );

  pe_accum_ctrl_cnt #(.WIDTH(PIPE_CNT_WIDTH)) u_pipe_cnt (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (pipe_load),
    .load_val_i (PIPE_LOAD),
    .dec_i      (pipe_dec),
    .zero_o     (pipe_zero)
  );

  assign ctrl.o_feature_ready        = feature_ready;
  assign ctrl.o_pe_feature_valid     = ctrl.i_feature_valid & feature_ready;
  assign ctrl.o_pe_flush_accumulator = flush;
  assign ctrl.o_result_capture       = capture;
  assign ctrl.o_result_valid         = result_valid;
  assign o_busy                      = state_is_busy(state_q);
  assign o_done                      = done;

`ifdef PE_ACCUM_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && i_start) begin
      stall_d = '0;
    end else if (((state_q == ACCUM) && !ctrl.i_feature_valid) ||
                 ((state_q == DRAIN) && !ctrl.i_result_ready)) begin
      if (stall_q != '1) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// tb/tb_pe_accum_ctrl.sv - directed scoreboard bench for pe_accum_ctrl (PIPE_LATENCY=4).

module tb_pe_accum_ctrl;

  localparam int LW = 16;
  localparam int PL = 4;

  localparam int K_FLUSH = 1;
  localparam int K_CAP   = 2;
  localparam int K_RV    = 3;
  localparam int K_DONE  = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          i_start;
  logic [LW-1:0] i_accum_len;
  logic [LW-1:0] i_num_windows;
  logic          o_busy;
  logic          o_done;
`ifdef PE_ACCUM_CTRL_PERF_EN
  logic [31:0]   o_stall_cycles;
`endif

  pe_accum_ctrl_if ctrl();

  pe_accum_ctrl #(.LEN_WIDTH(LW), .PIPE_LATENCY(PL)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .i_start        (i_start),
    .i_accum_len    (i_accum_len),
    .i_num_windows  (i_num_windows),
    .ctrl           (ctrl),
    .o_busy         (o_busy),
`ifdef PE_ACCUM_CTRL_PERF_EN
    .o_stall_cycles (o_stall_cycles),
`endif
    .o_done         (o_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  rd_obs   = 0;
  int  ncyc     = 0;
  int  beats    = 0;
  int  busy_cyc = 0;
  int  drain_fr = 0;
  int  checks   = 0;
  int  errors   = 0;

  // Monitor: samples on the falling edge and logs each output event with its cycle number.
  always @(negedge clock) begin
    ncyc = ncyc + 1;
    if (ctrl.o_pe_flush_accumulator === 1'b1) obs_q.push_back('{kind: K_FLUSH, cyc: ncyc});
    if (ctrl.o_result_capture === 1'b1)       obs_q.push_back('{kind: K_CAP,   cyc: ncyc});
    if (ctrl.o_result_valid === 1'b1)         obs_q.push_back('{kind: K_RV,    cyc: ncyc});
    if (o_done === 1'b1)                      obs_q.push_back('{kind: K_DONE,  cyc: ncyc});
    if (ctrl.o_pe_feature_valid === 1'b1) beats = beats + 1;
    if (o_busy === 1'b1) busy_cyc = busy_cyc + 1;
    if ((ctrl.o_result_valid === 1'b1) && (ctrl.o_feature_ready !== 1'b0)) drain_fr = drain_fr + 1;
  end

  task automatic check(input string tag, input integer obs, input integer exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fv, input logic rr);
    @(posedge clock);
    #1;
    i_start              = st;
    ctrl.i_feature_valid = fv;
    ctrl.i_result_ready  = rr;
  endtask

  task automatic expect_ev(input int kind, input int cyc);
    exp_q.push_back('{kind: kind, cyc: cyc});
  endtask

  task automatic score(input string name);
    ev_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_obs < obs_q.size()) begin
        check({name, "_kind"}, obs_q[rd_obs].kind, e.kind);
        check({name, "_cyc"}, obs_q[rd_obs].cyc, e.cyc);
        rd_obs = rd_obs + 1;
      end else begin
        check({name, "_missing"}, -1, e.kind);
      end
    end
    check({name, "_extra_events"}, obs_q.size(), rd_obs);
    rd_obs = obs_q.size();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"},  o_busy, 0);
    check({name, "_done"},  o_done, 0);
    check({name, "_fready"}, ctrl.o_feature_ready, 0);
    check({name, "_pevalid"}, ctrl.o_pe_feature_valid, 0);
    check({name, "_flush"}, ctrl.o_pe_flush_accumulator, 0);
    check({name, "_cap"},   ctrl.o_result_capture, 0);
    check({name, "_rv"},    ctrl.o_result_valid, 0);
`ifdef PE_ACCUM_CTRL_PERF_EN
    check({name, "_stall"}, o_stall_cycles, 0);
`endif
  endtask

  initial begin
    int s;
    int b0;
    int bz0;
    int fr0;

    resetn               = 1'b0;
    i_start              = 1'b0;
    i_accum_len          = '0;
    i_num_windows        = '0;
    ctrl.i_feature_valid = 1'b1;
    ctrl.i_result_ready  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // len=4, windows=2, continuous valid and ready.
    i_accum_len = 16'd4; i_num_windows = 16'd2;
    drive(1'b1, 1'b1, 1'b1);
    s = ncyc + 1; b0 = beats; bz0 = busy_cyc;
    expect_ev(K_FLUSH, s + 1);  expect_ev(K_CAP, s + 8);   expect_ev(K_RV, s + 9);
    expect_ev(K_FLUSH, s + 10); expect_ev(K_CAP, s + 17);  expect_ev(K_RV, s + 18);
    expect_ev(K_DONE, s + 19);
    for (int k = 1; k <= 21; k++) drive(1'b0, 1'b1, 1'b1);
    check("s1_beats", beats - b0, 8);
    check("s1_busy_cycles", busy_cyc - bz0, 19);
    check("s1_idle", o_busy, 0);
    score("s1");

    // windows=0: straight to DONE.
    i_accum_len = 16'd5; i_num_windows = 16'd0;
    drive(1'b1, 1'b1, 1'b1);
    s = ncyc + 1; b0 = beats; bz0 = busy_cyc;
    expect_ev(K_DONE, s + 1);
    for (int k = 1; k <= 3; k++) drive(1'b0, 1'b1, 1'b1);
    check("s2_beats", beats - b0, 0);
    check("s2_busy_cycles", busy_cyc - bz0, 1);
    score("s2");

    // len=3 with 2-cycle valid gaps, ready held low 5 DRAIN cycles.
    i_accum_len = 16'd3; i_num_windows = 16'd1;
    drive(1'b1, 1'b0, 1'b0);
    s = ncyc + 1; b0 = beats; bz0 = busy_cyc; fr0 = drain_fr;
    expect_ev(K_FLUSH, s + 1); expect_ev(K_CAP, s + 11);
    for (int k = 12; k <= 17; k++) expect_ev(K_RV, s + k);
    expect_ev(K_DONE, s + 18);
    for (int k = 1; k <= 20; k++)
      drive(1'b0, (k == 1 || k == 4 || k >= 7), (k >= 17));
    check("s3_beats", beats - b0, 3);
    check("s3_busy_cycles", busy_cyc - bz0, 18);
    check("s3_fready_in_drain", drain_fr - fr0, 0);
`ifdef PE_ACCUM_CTRL_PERF_EN
    check("s3_stall_cycles", o_stall_cycles, 9);
`endif
    score("s3");

    // Reset during WAIT_PIPE discards the pending result.
    i_accum_len = 16'd2; i_num_windows = 16'd1;
    drive(1'b1, 1'b1, 1'b1);
    s = ncyc + 1;
    expect_ev(K_FLUSH, s + 1);
    for (int k = 1; k <= 4; k++) drive(1'b0, 1'b1, 1'b1);
    resetn = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    resetn = 1'b1;
    @(negedge clock);
    check_all_zero("s4_midreset");
    for (int k = 1; k <= 6; k++) drive(1'b0, 1'b1, 1'b1);
    score("s4_abort");

    i_accum_len = 16'd1; i_num_windows = 16'd1;
    drive(1'b1, 1'b1, 1'b1);
    s = ncyc + 1; b0 = beats;
    expect_ev(K_FLUSH, s + 1); expect_ev(K_CAP, s + 5); expect_ev(K_RV, s + 6);
    expect_ev(K_DONE, s + 7);
    for (int k = 1; k <= 9; k++) drive(1'b0, 1'b1, 1'b1);
    check("s4_restart_beats", beats - b0, 1);
    score("s4_restart");

    // len=0 runs single-beat windows; a mid-job start is ignored.
    i_accum_len = 16'd0; i_num_windows = 16'd2;
    drive(1'b1, 1'b1, 1'b1);
    s = ncyc + 1; b0 = beats; bz0 = busy_cyc;
    expect_ev(K_FLUSH, s + 1); expect_ev(K_CAP, s + 5);  expect_ev(K_RV, s + 6);
    expect_ev(K_FLUSH, s + 7); expect_ev(K_CAP, s + 11); expect_ev(K_RV, s + 12);
    expect_ev(K_DONE, s + 13);
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        i_accum_len = 16'd7; i_num_windows = 16'd5;
      end
      drive((k == 3), 1'b1, 1'b1);
    end
    check("s5_beats", beats - b0, 2);
    check("s5_busy_cycles", busy_cyc - bz0, 13);
    check("s5_idle", o_busy, 0);
    score("s5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_accum_ctrl.md
PE_ACCUM_CTRL -- requirements
Module: pe_accum_ctrl

Interface
REQ-001 The module SHALL have parameter LEN_WIDTH, default 16, giving the width of the beat and window count fields.
REQ-002 The module SHALL have parameter PIPE_LATENCY, default 4 (legal range 1..15), giving the cycles from the last feature beat to a stable accumulator result.
REQ-003 Port: clock  in  1  single clock; all logic rising-edge.
REQ-004 Port: resetn  in  1  synchronous, active-low reset.
REQ-005 Port: i_start  in  1  starts a job when idle.
REQ-006 Port: i_accum_len  in  LEN_WIDTH  feature beats per accumulation window; latched at start.
REQ-007 Port: i_num_windows  in  LEN_WIDTH  windows per job; latched at start.
REQ-008 Port: i_feature_valid  in  1  upstream feature beat available.
REQ-009 Port: o_feature_ready  out  1  controller accepts a feature beat.
REQ-010 Port: o_pe_feature_valid  out  1  feature_valid to the accumulator array.
REQ-011 Port: o_pe_flush_accumulator  out  1  flush_accumulator to the accumulator array.
REQ-012 Port: o_result_capture  out  1  one-cycle strobe; the result register latches the accumulator outputs.
REQ-013 Port: o_result_valid  out  1  captured result is available downstream.
REQ-014 Port: i_result_ready  in  1  downstream accepts the result.
REQ-015 Port: o_busy  out  1  a job is in progress.
REQ-016 Port: o_done  out  1  one-cycle pulse when the job completes.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM, WAIT_PIPE, DRAIN and DONE.
REQ-018 In IDLE, i_start SHALL latch the lengths and move to ACCUM; if i_num_windows=0, it SHALL move to DONE instead.
REQ-019 i_start outside IDLE SHALL be ignored.
REQ-020 o_feature_ready SHALL be 1 only in ACCUM; o_pe_feature_valid = i_feature_valid & o_feature_ready, combinational.
REQ-021 o_pe_flush_accumulator SHALL be 1 exactly on the first accepted beat of each window, in the same cycle as o_pe_feature_valid.
REQ-022 i_accum_len=0 SHALL be treated as 1.
REQ-023 After the last beat of a window is accepted, the FSM SHALL enter WAIT_PIPE for exactly PIPE_LATENCY cycles.
REQ-024 o_result_capture SHALL pulse on the last WAIT_PIPE cycle, and the next state SHALL be DRAIN.
REQ-025 In DRAIN, o_result_valid SHALL be 1 and SHALL stay 1 until i_result_ready=1.
REQ-026 On the DRAIN handshake, the FSM SHALL go to ACCUM if windows remain, otherwise to DONE.
REQ-027 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 Feature-beat gaps (i_feature_valid=0) SHALL stall the beat counter; no timeout.
REQ-030 The minimum window time SHALL be len + PIPE_LATENCY + 1 cycles.

Reset
REQ-031 With resetn=0 at a clock edge, the FSM SHALL go to IDLE, counters SHALL clear, and all outputs SHALL be 0, including mid-job.
REQ-032 A result pending at reset SHALL be discarded.

Configuration
REQ-033 Macro PE_ACCUM_CTRL_PERF_EN SHALL add output o_stall_cycles[31:0] counting cycles in ACCUM with i_feature_valid=0 plus DRAIN cycles with i_result_ready=0.
REQ-034 o_stall_cycles SHALL clear on job start and saturate at 2^32-1.
REQ-035 Without PE_ACCUM_CTRL_PERF_EN, the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-036 The state enum (pe_accum_ctrl_state_t) SHALL live in pe_types.
REQ-037 Sub-module pe_accum_ctrl_cnt (loadable down-counter with zero flag) SHALL be used for the beat, window and pipe counters.

Verification
REQ-038 Scenario: len=4, windows=2, PIPE_LATENCY=4, continuous valid, ready=1 -> flush on beats 1 and 5; capture 4 cycles after beat 4; o_done 1 cycle after the second handshake.
REQ-039 Scenario: windows=0 -> o_busy for 1 cycle, o_done pulse, no feature_valid, flush or capture.
REQ-040 Scenario: len=3 with valid gaps of 2 cycles, i_result_ready held low for 5 cycles -> o_result_valid held 6 cycles; o_feature_ready=0 throughout DRAIN.
REQ-041 Scenario: resetn=0 during WAIT_PIPE -> next cycle all outputs 0, IDLE; a new start works normally.
REQ-042 Scenario: i_start pulsed mid-job and len=0 -> start ignored; len=0 runs as single-beat windows.
REQ-043 Scenario (PERF_EN): 3 valid gaps plus 2 ready-low cycles -> o_stall_cycles=5 at o_done.
